// File: rtl/window_addr_pkg.sv
// Shared types and elaboration-time helpers for the window address generator.
package window_addr_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEmit,
    StWait
  } state_e;

  // Number of window positions along one axis for image extent img, window extent win, step s.
  function automatic int unsigned calc_npos(input int unsigned img, input int unsigned win,
                                            input int unsigned s);
    return (img - win) / s + 1;
  endfunction

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int unsigned calc_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Address width for an img_w x img_h raster.
  function automatic int unsigned calc_addr_w(input int unsigned img_w, input int unsigned img_h);
    return calc_width(img_w * img_h);
  endfunction

endpackage

// File: rtl/window_addr_generator_stride_counter.sv
// Position counter with run-time step and terminal count; tracks count*step by accumulation.
module stride_counter #(
  parameter int unsigned CntW = 4,
  parameter int unsigned OffW = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_clear,
  input  logic            i_step_en,
  input  logic [OffW-1:0] i_step,
  input  logic [CntW-1:0] i_last,
  output logic [CntW-1:0] o_count,
  output logic [OffW-1:0] o_offset,
  output logic [OffW-1:0] o_offset_next,
  output logic            o_terminal
);

  logic [CntW-1:0] r_count;
  logic [OffW-1:0] r_offset;

  // Terminal flag and the offset this counter will hold after its next step (wraps to 0).
  always_comb begin
    o_terminal    = (r_count == i_last);
    o_offset_next = o_terminal ? '0 : r_offset + i_step;
  end

  // Count and accumulated offset; clear wins over step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_offset <= '0;
    end else if (i_clear) begin
      r_count  <= '0;
      r_offset <= '0;
    end else if (i_step_en) begin
      r_count  <= o_terminal ? '0 : r_count + CntW'(1);
      r_offset <= o_offset_next;
    end
  end

  assign o_count  = r_count;
  assign o_offset = r_offset;

endmodule

// File: rtl/window_addr_generator.sv
// Walks a WIN_ROWS x WIN_COLS window over a raster image and emits one row-start address
// per window line over a valid/ready handshake.
module window_addr_generator
  import window_addr_pkg::*;
#(
  parameter int unsigned IMG_W      = 13,
  parameter int unsigned IMG_H      = 13,
  parameter int unsigned WIN_ROWS   = 4,
  parameter int unsigned WIN_COLS   = 4,
  parameter int unsigned STRIDE_MAX = 4,
  parameter int unsigned ADDR_W     = calc_addr_w(IMG_W, IMG_H)
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst_n,
  input  logic                                      i_start,
  input  logic [calc_width(STRIDE_MAX+1)-1:0]       i_stride,
  input  logic                                      i_abort,
  input  logic                                      i_next_window,
  output logic [ADDR_W-1:0]                         o_addr,
  output logic                                      o_addr_valid,
  input  logic                                      i_addr_ready,
  output logic [calc_width(WIN_ROWS)-1:0]           o_line_idx,
  output logic                                      o_window_done,
  output logic                                      o_frame_done,
  output logic                                      o_start_err,
  output logic                                      o_busy
);

  localparam int unsigned StrideW = calc_width(STRIDE_MAX + 1);
  localparam int unsigned LineW   = calc_width(WIN_ROWS);
  localparam int unsigned CntRW   = calc_width(calc_npos(IMG_H, WIN_ROWS, 1));
  localparam int unsigned CntCW   = calc_width(calc_npos(IMG_W, WIN_COLS, 1));
  localparam logic [LineW-1:0] LineLast = LineW'(WIN_ROWS - 1);

  state_e r_state, w_state_next;

  logic [StrideW-1:0] r_stride;
  logic [CntRW-1:0]   r_last_r, w_last_r;
  logic [CntCW-1:0]   r_last_c, w_last_c;
  logic [ADDR_W-1:0]  r_row_step, w_row_step;
  logic [ADDR_W-1:0]  r_addr;
  logic [LineW-1:0]   r_line;
  logic               r_window_done, r_frame_done, r_start_err;

  logic w_stride_ok, w_start_ok, w_start_bad, w_abort, w_hs, w_last_line, w_last_pos, w_nw;
  logic w_win_end;

  logic [CntRW-1:0]  w_row_cnt;
  logic [CntCW-1:0]  w_col_cnt;
  logic [ADDR_W-1:0] w_row_off, w_row_off_next, w_col_off, w_col_off_next, w_next_base;
  logic              w_row_term, w_col_term;
  logic              w_unused;

  // Per-stride terminal counts and row step, as a small constant table indexed by i_stride.
  always_comb begin
    w_last_r   = '0;
    w_last_c   = '0;
    w_row_step = '0;
    for (int unsigned s = 1; s <= STRIDE_MAX; s++) begin
      if (i_stride == StrideW'(s)) begin
        w_last_r   = CntRW'(calc_npos(IMG_H, WIN_ROWS, s) - 1);
        w_last_c   = CntCW'(calc_npos(IMG_W, WIN_COLS, s) - 1);
        w_row_step = ADDR_W'(s * IMG_W);
      end
    end
  end

  // Handshake and event decode.
  always_comb begin
    w_stride_ok = (i_stride != '0) && (i_stride <= StrideW'(STRIDE_MAX));
    w_start_ok  = (r_state == StIdle) && i_start && w_stride_ok;
    w_start_bad = (r_state == StIdle) && i_start && !w_stride_ok;
    w_abort     = (r_state != StIdle) && i_abort;
    w_hs        = (r_state == StEmit) && i_addr_ready && !i_abort;
    w_last_line = (r_line == LineLast);
    w_last_pos  = w_row_term && w_col_term;
    w_win_end   = w_hs && w_last_line;
    w_nw        = (r_state == StWait) && i_next_window && !i_abort;
    // Row only advances when the column wraps; a row wrap never happens here since the
    // last position ends the frame instead of entering WAIT.
    w_next_base = w_col_off_next + (w_col_term ? w_row_off_next : w_row_off);
  end

  stride_counter #(
    .CntW (CntRW),
    .OffW (ADDR_W)
  ) u_pos_row (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (w_start_ok),
    .i_step_en     (w_nw && w_col_term),
    .i_step        (r_row_step),
    .i_last        (r_last_r),
    .o_count       (w_row_cnt),
    .o_offset      (w_row_off),
    .o_offset_next (w_row_off_next),
    .o_terminal    (w_row_term)
  );

  stride_counter #(
    .CntW (CntCW),
    .OffW (ADDR_W)
  ) u_pos_col (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clear       (w_start_ok),
    .i_step_en     (w_nw),
    .i_step        (ADDR_W'(r_stride)),
    .i_last        (r_last_c),
    .o_count       (w_col_cnt),
    .o_offset      (w_col_off),
    .o_offset_next (w_col_off_next),
    .o_terminal    (w_col_term)
  );

  // Position counts are only needed through their terminal flags.
  assign w_unused = ^{w_row_cnt, w_col_cnt};

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Next-state logic; abort takes priority over handshake and next_window.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_start_ok) w_state_next = StEmit;
      StEmit: begin
        if (w_abort)        w_state_next = StIdle;
        else if (w_win_end) w_state_next = w_last_pos ? StIdle : StWait;
      end
      StWait: begin
        if (w_abort)   w_state_next = StIdle;
        else if (w_nw) w_state_next = StEmit;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    o_addr_valid = (r_state == StEmit);
    o_busy       = (r_state != StIdle);
  end

  // Address, line index, latched configuration and event pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stride      <= '0;
      r_last_r      <= '0;
      r_last_c      <= '0;
      r_row_step    <= '0;
      r_addr        <= '0;
      r_line        <= '0;
      r_window_done <= 1'b0;
      r_frame_done  <= 1'b0;
      r_start_err   <= 1'b0;
    end else begin
      r_window_done <= w_win_end;
      r_frame_done  <= w_win_end && w_last_pos;
      r_start_err   <= w_start_bad;
      if (w_start_ok) begin
        r_stride   <= i_stride;
        r_last_r   <= w_last_r;
        r_last_c   <= w_last_c;
        r_row_step <= w_row_step;
        r_addr     <= '0;
        r_line     <= '0;
      end else if (w_hs && !w_last_line) begin
        r_addr <= r_addr + ADDR_W'(IMG_W);
        r_line <= r_line + LineW'(1);
      end else if (w_nw) begin
        r_addr <= w_next_base;
        r_line <= '0;
      end
    end
  end

  assign o_addr        = r_addr;
  assign o_line_idx    = r_line;
  assign o_window_done = r_window_done;
  assign o_frame_done  = r_frame_done;
  assign o_start_err   = r_start_err;

endmodule

// File: tb/tb_window_addr_generator.sv
// Self-checking bench for window_addr_generator: table-driven frame walks against an
// arithmetic reference model, plus directed corner-case sequences.
module tb_window_addr_generator;

  localparam int unsigned IMG_W = 13;
  localparam int unsigned IMG_H = 13;
  localparam int unsigned WIN_ROWS = 4;
  localparam int unsigned WIN_COLS = 4;
  localparam int unsigned FRAME_LIMIT = 4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start, i_abort, i_next_window, i_addr_ready;
  logic [2:0] i_stride;
  logic [7:0] o_addr;
  logic [1:0] o_line_idx;
  logic       o_addr_valid, o_window_done, o_frame_done, o_start_err, o_busy;

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned exp_addr_q[$];
  int unsigned exp_line_q[$];
  int unsigned got_line0[$];
  int unsigned got_last;

  typedef struct {
    int unsigned stride;
    bit          rnd;
    int unsigned exp_wins;
    int unsigned probe_win;
    int unsigned probe_addr;
    int unsigned last_addr;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  window_addr_generator dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (i_start),
    .i_stride      (i_stride),
    .i_abort       (i_abort),
    .i_next_window (i_next_window),
    .o_addr        (o_addr),
    .o_addr_valid  (o_addr_valid),
    .i_addr_ready  (i_addr_ready),
    .o_line_idx    (o_line_idx),
    .o_window_done (o_window_done),
    .o_frame_done  (o_frame_done),
    .o_start_err   (o_start_err),
    .o_busy        (o_busy)
  );

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_addr"}, o_addr, 0);
    check({name, "_valid"}, o_addr_valid, 0);
    check({name, "_line"}, o_line_idx, 0);
    check({name, "_pulses"}, {o_window_done, o_frame_done, o_start_err}, 0);
    check({name, "_busy"}, o_busy, 0);
  endtask

  // Reference: every window position in raster order, each line at (r+line)*IMG_W + c.
  task automatic build_model(input int unsigned s);
    int unsigned nr, nc;
    nr = (IMG_H - WIN_ROWS) / s + 1;
    nc = (IMG_W - WIN_COLS) / s + 1;
    exp_addr_q.delete();
    exp_line_q.delete();
    for (int unsigned pr = 0; pr < nr; pr++)
      for (int unsigned pc = 0; pc < nc; pc++)
        for (int unsigned ln = 0; ln < WIN_ROWS; ln++) begin
          exp_addr_q.push_back((pr * s + ln) * IMG_W + pc * s);
          exp_line_q.push_back(ln);
        end
  endtask

  // Called at a negedge; returns at the negedge after the start has been accepted.
  task automatic start_frame(input int unsigned s);
    i_start  = 1'b1;
    i_stride = 3'(s);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int  wins, cyc, nw_cnt;
    bit  done;
    int unsigned ea, el;
    build_model(v.stride);
    got_line0.delete();
    got_last = 0;
    wins = 0; cyc = 0; nw_cnt = -1; done = 0;
    i_addr_ready = 1'b1;
    start_frame(v.stride);
    while (!done && cyc < FRAME_LIMIT) begin
      if (o_window_done) begin
        wins++;
        nw_cnt = v.rnd ? int'($urandom_range(0, 2)) : 0;
        check("frame_done_coincide", o_frame_done, (wins == int'(v.exp_wins)) ? 1 : 0);
      end else if (o_frame_done) begin
        check("frame_done_alone", o_window_done, 1);
      end
      if (o_frame_done) done = 1;
      i_next_window = (nw_cnt == 0);
      if (nw_cnt >= 0) nw_cnt--;
      i_addr_ready = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!done && o_addr_valid && i_addr_ready) begin
        if (exp_addr_q.size() == 0) begin
          check("extra_addr", o_addr, 0);
        end else begin
          ea = exp_addr_q.pop_front();
          el = exp_line_q.pop_front();
          check("addr", o_addr, ea);
          check("line_idx", o_line_idx, el);
          if (el == 0) got_line0.push_back(o_addr);
          got_last = o_addr;
        end
      end
      cyc++;
      @(negedge clk);
    end
    i_next_window = 1'b0;
    check("frame_end_seen", done, 1);
    check("window_count", wins, v.exp_wins);
    check("model_drained", exp_addr_q.size(), 0);
    check("busy_after_frame", o_busy, 0);
    check("valid_after_frame", o_addr_valid, 0);
    if (got_line0.size() > v.probe_win) check("probe_line0", got_line0[v.probe_win], v.probe_addr);
    else check("probe_present", got_line0.size(), v.probe_win + 1);
    check("last_addr", got_last, v.last_addr);
  endtask

  // Step until line 2 of the current window is presented (ready held high).
  task automatic reach_line2();
    int k = 0;
    while (!(o_addr_valid && o_line_idx == 2) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("reach_line2", o_line_idx, 2);
  endtask

  initial begin
    int wins, k;
    rst_n = 1'b0;
    i_start = 1'b0; i_stride = '0; i_abort = 1'b0; i_next_window = 1'b0; i_addr_ready = 1'b0;

    // stride, rnd, windows, probe window, probe line-0 addr, last addr
    vecs[0] = '{stride: 1, rnd: 0, exp_wins: 100, probe_win: 1,  probe_addr: 1,   last_addr: 165};
    vecs[1] = '{stride: 2, rnd: 1, exp_wins: 25,  probe_win: 5,  probe_addr: 26,  last_addr: 151};
    vecs[2] = '{stride: 3, rnd: 0, exp_wins: 16,  probe_win: 6,  probe_addr: 45,  last_addr: 165};
    vecs[3] = '{stride: 4, rnd: 1, exp_wins: 9,   probe_win: 4,  probe_addr: 56,  last_addr: 151};
    vecs[4] = '{stride: 1, rnd: 1, exp_wins: 100, probe_win: 99, probe_addr: 126, last_addr: 165};
    vecs[5] = '{stride: 3, rnd: 1, exp_wins: 16,  probe_win: 15, probe_addr: 126, last_addr: 165};

    repeat (2) @(negedge clk);
    check_idle_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    // Illegal strides: error pulse for one cycle, block stays idle.
    foreach (vecs[i]) begin end
    for (int i = 0; i < 2; i++) begin
      start_frame((i == 0) ? 0 : 5);
      check("start_err_pulse", o_start_err, 1);
      check("start_err_busy", o_busy, 0);
      @(negedge clk);
      check("start_err_clear", o_start_err, 0);
      check("start_err_idle", o_busy, 0);
    end

    // Full frame walks; the stride-2 entry follows the illegal starts.
    for (int i = 0; i < 6; i++) begin
      if (i == 0) run_frame(vecs[1]);
      else if (i == 1) run_frame(vecs[0]);
      else run_frame(vecs[i]);
      @(negedge clk);
    end

    // Backpressure on line 2: address and index hold, then advance on handshake.
    i_addr_ready = 1'b1;
    start_frame(1);
    check("first_addr_latency", o_addr_valid, 1);
    reach_line2();
    i_addr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_addr_hold", o_addr, 26);
      check("bp_line_hold", o_line_idx, 2);
      check("bp_valid_hold", o_addr_valid, 1);
    end
    i_addr_ready = 1'b1;
    @(negedge clk);
    check("bp_advance_addr", o_addr, 39);
    check("bp_advance_line", o_line_idx, 3);
    // Abort beats a simultaneous last-line handshake.
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    check("abort_emit_busy", o_busy, 0);
    check("abort_emit_wdone", o_window_done, 0);
    check("abort_emit_valid", o_addr_valid, 0);

    // Abort in WAIT after seven windows.
    i_addr_ready = 1'b1;
    start_frame(1);
    wins = 0; k = 0;
    while (wins < 7 && k < 200) begin
      @(negedge clk);
      k++;
      i_next_window = 1'b0;
      if (o_window_done) begin
        wins++;
        if (wins < 7) i_next_window = 1'b1;
      end
    end
    check("abort_wait_reached", wins, 7);
    check("abort_wait_state", {o_busy, o_addr_valid}, 2'b10);
    i_abort = 1'b1;
    i_next_window = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    i_next_window = 1'b0;
    check("abort_wait_busy", o_busy, 0);
    check("abort_wait_valid", o_addr_valid, 0);
    check("abort_wait_pulses", {o_window_done, o_frame_done}, 0);
    @(negedge clk);
    check("abort_wait_no_fdone", o_frame_done, 0);
    start_frame(1);
    check("restart_addr", o_addr, 0);
    check("restart_line", o_line_idx, 0);
    check("restart_valid", o_addr_valid, 1);

    // Asynchronous reset while emitting line 2.
    reach_line2();
    i_addr_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    i_next_window = 1'b1;
    @(negedge clk);
    i_next_window = 1'b0;
    check("post_reset_busy", o_busy, 0);
    check("post_reset_valid", o_addr_valid, 0);
    check("post_reset_wdone", o_window_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/window_addr_generator.md
Name: window_addr_generator

Overview:
- Parametrised successor to the fixed 13-wide / 10x10-position / 4-line window address generator.
- Walks a WIN_ROWS x WIN_COLS window over an IMG_W x IMG_H raster-stored image, with a run-time stride.
- For each window position, emits one row-start memory address per window line over a valid/ready handshake.
- Sits between the control FSM (start / next_window) and the input buffer memory read port.

Parameters:
- IMG_W, 13, image width in pixels (words per memory row)
- IMG_H, 13, image height in rows
- WIN_ROWS, 4, window lines emitted per position
- WIN_COLS, 4, window width, used only for horizontal position count
- STRIDE_MAX, 4, largest legal stride
- ADDR_W, $clog2(IMG_W*IMG_H), address width (derived)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin a frame walk (accepted only in IDLE)
- stride  in  $clog2(STRIDE_MAX+1)  step for both axes, sampled on accepted start
- abort  in  1  synchronous abandon of current frame
- next_window  in  1  consumer finished the current window; advance position
- addr  out  ADDR_W  row-start address of the current window line
- addr_valid  out  1  addr holds a line address
- addr_ready  in  1  consumer accepts addr this cycle
- line_idx  out  $clog2(WIN_ROWS)  line index of addr
- window_done  out  1  one-cycle pulse after the last line of a window is accepted
- frame_done  out  1  one-cycle pulse after the last window of the frame completes
- start_err  out  1  one-cycle pulse: start seen in IDLE with stride 0 or > STRIDE_MAX
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; all counters 0; addr=0; all outputs 0.
- Position counts: NPOS_R=(IMG_H-WIN_ROWS)/s+1 and NPOS_C=(IMG_W-WIN_COLS)/s+1, integer floor, s = latched stride.
- Address: addr = (r + line_idx)*IMG_W + c, where r = pos_row*s and c = pos_col*s.
  - Held in registers; updated incrementally (add IMG_W per line, add s per column step). No multiplier on the output path.
- FSM states: IDLE, EMIT, WAIT.
- IDLE:
  - start with a legal stride: latch s; clear all counters; next cycle EMIT with addr_valid=1, addr=0.
  - start with an illegal stride: start_err pulses the next cycle; remain IDLE.
- EMIT:
  - addr_valid=1. addr and line_idx hold stable while addr_ready=0.
  - A handshake (valid & ready) on a non-last line: line_idx+1 and addr+IMG_W on the next cycle.
  - Handshake on line WIN_ROWS-1: next cycle addr_valid=0 and window_done=1.
    - If it was the last position (pos_row=NPOS_R-1 and pos_col=NPOS_C-1): frame_done=1 in the same cycle as window_done, and state goes to IDLE.
    - Otherwise state goes to WAIT.
- WAIT:
  - addr_valid=0. On next_window: advance pos_col; if pos_col wraps past NPOS_C-1, set it to 0 and advance pos_row. Reset line_idx=0.
  - Next cycle EMIT with the new window's line-0 address.
- next_window outside WAIT: ignored. start outside IDLE: ignored (no start_err).
- abort in EMIT or WAIT: next cycle IDLE, addr_valid=0, no window_done or frame_done. abort has priority over a simultaneous handshake or next_window.
- Reset mid-operation: immediate return to reset values; no pulses generated.
- Throughput: one address per cycle while addr_ready=1. Latency from start to first valid is 1 cycle.
- The default configuration (13x13, 4x4, s=1) gives 10x10 positions, reproducing the previous generator's address sequence.

Decomposition:
- Shared package window_addr_pkg holds:
  - state enum (IDLE, EMIT, WAIT)
  - localparam functions for NPOS_R, NPOS_C, ADDR_W
- One sub-module, stride_counter: a position counter with a run-time step and a run-time terminal count.
  - Outputs: count, scaled offset (count*s, accumulated), terminal flag.
  - Instantiated twice: pos_row and pos_col.

Test Plan:
- Defaults, s=1, addr_ready=1, next_window pulsed one cycle after each window_done:
  - window (0,0) emits 0, 13, 26, 39; window (0,1) emits 1, 14, 27, 40.
  - 100 window_done pulses; frame_done coincides with the 100th.
  - Last window emits 126, 139, 152, 165.
- s=3, defaults otherwise: NPOS=4x4; window (1,2) emits 45, 58, 71, 84. Exactly 16 window_done pulses.
- Backpressure: addr_ready held at 0 for 5 cycles on line 2. addr=26 and line_idx=2 stay stable; there is no advance until the handshake.
- stride=0 and stride=5 on start: start_err pulses and busy stays 0. A following start with s=2 gives NPOS=5x5.
- abort during WAIT after window 7: state returns to IDLE with no frame_done. A new start restarts at addr 0.
- rst asserted mid-EMIT (line 2): outputs drop to 0 asynchronously. After release, the block is in IDLE and ignores next_window.
